event_stream_framer: RTL and testbench
======================================

# event_stream_framer

Downstream of the memory readout stage: takes the 45-bit `mem_dat_stream` / `valid` / `none` output plus the `new_event` / `BX` event markers, and frames each event as header + payload words + trailer. The framed words go into a 32-entry first-word-fall-through FIFO. A ready/valid handshake presents them to the link serializer, so readout can run at full rate while the link back-pressures.

## Interface
Parameters:
- `DATA_W`, 45, payload word width
- `BX_W`, 3, BX number width
- `AW`, 5, FIFO address width (depth 2^AW = 32)
- `CNT_W`, 6, trailer payload-count width

Ports:
- `clk`  in  1  main clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `new_event`  in  1  single-cycle start of a new event
- `BX`  in  BX_W  BX number, sampled with `new_event`
- `mem_dat_stream`  in  DATA_W  readout payload word
- `valid`  in  1  `mem_dat_stream` holds a valid word this cycle
- `none`  in  1  readout has no more items for the current event
- `out_data`  out  DATA_W+2  framed word, [DATA_W+1:DATA_W] = tag
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  consumer accepts `out_data`
- `fill`  out  AW+1  FIFO occupancy, 0..32
- `lost_evt_cnt`  out  8  events dropped for lack of space
- `stray_cnt`  out  8  words received with no open event

## Operation
- Tags: 2'b01 = header, 2'b00 = payload, 2'b10 = trailer.
- Header word: [2:0] = BX, all other data bits 0.
- Payload word: data bits = `mem_dat_stream`.
- Trailer word:
  - [44] = overflow
  - [43:41] = BX
  - [CNT_W-1:0] = count of accepted payload words, saturating at 63
  - other bits 0
- Free-slot rule: `free` = 32 − `fill`, taken from occupancy before the edge. Pops in the same cycle do not count toward `free`.
- One slot is always reserved for the pending trailer:
  - header is written only if free ≥ 2
  - payload is written only if free ≥ 2
  - trailer is written if free ≥ 1, which is guaranteed
- Input FSM states: IDLE, OPEN, HDR_PEND, DROP.
- IDLE:
  - `new_event` with free ≥ 2: write header, latch BX, clear count and overflow, go to OPEN.
  - `new_event` with free < 2: increment `lost_evt_cnt`, go to DROP.
  - `valid`: discard the word, increment `stray_cnt`.
  - `none` is ignored.
- OPEN:
  - `new_event`: write trailer of the current event, go to HDR_PEND. The new BX is latched.
  - Otherwise `valid`: write payload if free ≥ 2 and increment count; else drop the word and set overflow.
  - Otherwise `none` (with `valid`=0): write trailer, go to IDLE.
  - `valid` and `none` together: the word is handled first; the event closes on a later cycle with `none` and no `valid`.
- HDR_PEND:
  - Applies the IDLE header rule for the latched BX.
  - A `valid` word this cycle is dropped and sets overflow of the new event.
  - A `new_event` this cycle replaces the latched BX and stays in HDR_PEND.
- DROP:
  - All `valid` words are discarded.
  - `none` with `valid`=0 returns to IDLE.
  - `new_event` applies the IDLE rule.
  - No trailer is written.
- Output: `out_valid` = (`fill` ≠ 0). `out_data` = FIFO head, forced to 0 when `out_valid`=0. Pop when `out_valid && out_ready`.
- Counters saturate at 255.

## Timing
- Reset (async assert, sync release), all zero:
  - read/write pointers, `fill`, `out_valid`, `out_data`
  - counters, count, overflow
  - FSM goes to IDLE
- Latency: a word written at edge N appears on `out_data` with `out_valid`=1 after edge N, if the FIFO was empty. Otherwise it appears behind earlier words, in order.
- Push and pop in the same cycle: `fill` stays unchanged. Push at full is impossible by construction. Pop at empty is ignored.
- `out_data` and `out_valid` hold stable while `out_valid && !out_ready`.
- Pointers wrap modulo 32. `fill` is distinguished from full using the AW+1-bit pointers.
- Asserting `reset_n` low mid-event discards FIFO contents and the partial event, with no trailer emitted.

## Configuration
- `FRAMER_STATS_EN`
  - Defined: `lost_evt_cnt` and `stray_cnt` counters are implemented as described.
  - Undefined: both ports are tied to 0 and no counter flops are built. Framing, drop and overflow behaviour are identical either way.

## Test plan
- Basic event, `out_ready`=1: `new_event` with BX=3, 4 valid words D0..D3, then `none` → out stream is:
  - header {01, BX=3}
  - D0..D3 tagged 00
  - trailer {10, ovf=0, BX=3, cnt=4}
  - then `fill` returns to 0.
- Back-pressure overflow, `out_ready`=0: event with 40 valid words → 30 payloads accepted, 10 dropped. `fill`=32; trailer cnt=30, ovf=1.
- Back-to-back events: `new_event` asserted while OPEN with BX=5, then BX=6 one cycle later. Required response:
  - BX=5 event gets its trailer
  - BX=6 header is written in the HDR_PEND cycle
  - a `valid` word in that cycle is dropped and the BX=6 trailer has ovf=1.
- Lost event: FIFO full, `out_ready`=0, `new_event` → DROP state, `lost_evt_cnt`=1. Later words and `none` produce no FIFO writes.
- Stray data and reset: `valid` pulses in IDLE → `stray_cnt` increments and no writes occur. Asserting `reset_n` low mid-payload → `out_valid`=0, `fill`=0 and the counters clear immediately, without a clock edge.

Source files
------------

// File: rtl/event_stream_framer.sv
`default_nettype none
// ============================================================================
// Module      : event_stream_framer
// Description : Frames readout events as header/payload/trailer words into a
//               32-entry FWFT FIFO drained by a ready/valid handshake.
//               Optional macro FRAMER_STATS_EN builds the lost/stray counters.
// Revision    : 1.0 - initial release
// ============================================================================
module event_stream_framer #(
    parameter int DATA_W = 45,
    parameter int BX_W   = 3,
    parameter int AW     = 5,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              new_event,
    input  logic [BX_W-1:0]   BX,
    input  logic [DATA_W-1:0] mem_dat_stream,
    input  logic              valid,
    input  logic              none,
    output logic [DATA_W+1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW:0]       fill,
    output logic [7:0]        lost_evt_cnt,
    output logic [7:0]        stray_cnt
);

    localparam int         c_DEPTH    = 1 << AW;
    localparam logic [AW:0] c_ROOM_MAX = (AW+1)'(c_DEPTH - 2);
    localparam logic [1:0] c_TAG_HDR  = 2'b01;
    localparam logic [1:0] c_TAG_PAY  = 2'b00;
    localparam logic [1:0] c_TAG_TRL  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_OPEN     = 2'd1,
        S_HDR_PEND = 2'd2,
        S_DROP     = 2'd3
    } state_t;

    state_t            r_state;
    logic [BX_W-1:0]   r_bx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [DATA_W+1:0] r_mem [c_DEPTH];

    logic              w_room;
    logic              w_pop;
    logic              w_push;
    logic [DATA_W+1:0] w_push_data;
    logic [BX_W-1:0]   w_hdr_bx;
    logic [DATA_W-1:0] w_hdr;
    logic [DATA_W-1:0] w_trl;

    // Occupancy comes from pointers one bit wider than the address, so 32 != 0.
    assign fill      = r_wr_ptr - r_rd_ptr;
    assign w_room    = (fill <= c_ROOM_MAX);
    assign out_valid = (fill != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
    assign w_pop     = out_valid && out_ready;
    assign w_hdr_bx  = (r_state == S_HDR_PEND) ? r_bx : BX;

    always_comb begin
        w_hdr                     = '0;
        w_hdr[BX_W-1:0]           = w_hdr_bx;
        w_trl                     = '0;
        w_trl[DATA_W-1]           = r_ovf;
        w_trl[DATA_W-2 -: BX_W]   = r_bx;
        w_trl[CNT_W-1:0]          = r_cnt;
    end

    // Header/payload need two free slots so the trailer always has one left.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = {c_TAG_HDR, w_hdr};
        case (r_state)
            S_IDLE, S_DROP: begin
                if (new_event && w_room)
                    w_push = 1'b1;
            end
            S_HDR_PEND: begin
                if (!new_event && w_room)
                    w_push = 1'b1;
            end
            S_OPEN: begin
                if (new_event || (none && !valid)) begin
                    w_push      = 1'b1;
                    w_push_data = {c_TAG_TRL, w_trl};
                end else if (valid && w_room) begin
                    w_push      = 1'b1;
                    w_push_data = {c_TAG_PAY, mem_dat_stream};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_bx    <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DROP: begin
                    if (new_event) begin
                        r_bx    <= BX;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= w_room ? S_OPEN : S_DROP;
                    end else if (r_state == S_DROP && none && !valid) begin
                        r_state <= S_IDLE;
                    end
                end
                S_OPEN: begin
                    if (new_event) begin
                        r_bx    <= BX;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= S_HDR_PEND;
                    end else if (valid) begin
                        if (w_room) begin
                            if (r_cnt != '1)
                                r_cnt <= r_cnt + CNT_W'(1);
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end else if (none) begin
                        r_state <= S_IDLE;
                    end
                end
                S_HDR_PEND: begin
                    // A word arriving before the header is written belongs to the new event.
                    if (new_event) begin
                        r_bx  <= BX;
                        r_ovf <= r_ovf | valid;
                    end else begin
                        r_cnt   <= '0;
                        r_ovf   <= r_ovf | valid;
                        r_state <= w_room ? S_OPEN : S_DROP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= w_push_data;
    end

`ifdef FRAMER_STATS_EN
    logic w_lost;
    logic w_stray;

    assign w_lost  = !w_room &&
                     ((new_event && (r_state == S_IDLE || r_state == S_DROP)) ||
                      (!new_event && r_state == S_HDR_PEND));
    assign w_stray = (r_state == S_IDLE) && valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lost_evt_cnt <= '0;
            stray_cnt    <= '0;
        end else begin
            if (w_lost && lost_evt_cnt != 8'hFF)
                lost_evt_cnt <= lost_evt_cnt + 8'd1;
            if (w_stray && stray_cnt != 8'hFF)
                stray_cnt <= stray_cnt + 8'd1;
        end
    end
`else
    assign lost_evt_cnt = '0;
    assign stray_cnt    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_event_stream_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_event_stream_framer
// Description : Directed self-checking bench for event_stream_framer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_event_stream_framer;

`ifdef FRAMER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        new_event = 1'b0;
    logic [2:0]  BX = '0;
    logic [44:0] mem_dat_stream = '0;
    logic        valid = 1'b0;
    logic        none = 1'b0;
    logic [46:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  fill;
    logic [7:0]  lost_evt_cnt;
    logic [7:0]  stray_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    event_stream_framer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .new_event      (new_event),
        .BX             (BX),
        .mem_dat_stream (mem_dat_stream),
        .valid          (valid),
        .none           (none),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fill           (fill),
        .lost_evt_cnt   (lost_evt_cnt),
        .stray_cnt      (stray_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [46:0] hdr_w(input logic [2:0] bx);
        return {2'b01, 42'd0, bx};
    endfunction

    function automatic logic [46:0] pay_w(input logic [44:0] d);
        return {2'b00, d};
    endfunction

    function automatic logic [46:0] trl_w(input logic ovf, input logic [2:0] bx, input logic [5:0] cnt);
        return {2'b10, ovf, bx, 35'd0, cnt};
    endfunction

    function automatic logic [44:0] dat(input int i);
        return {13'h1ABC, 32'(i) ^ 32'hDEAD_0000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        n_checks++; if (fill !== 6'd0) begin n_fail++; $display("FAIL reset_fill: got %0d exp 0", fill); end
        n_checks++; if (out_data !== 47'd0) begin n_fail++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
        n_checks++; if (lost_evt_cnt !== 8'd0 || stray_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_counters: got lost=%0d stray=%0d exp 0", lost_evt_cnt, stray_cnt); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        new_event = 1'b1; BX = 3'd3; tick(); new_event = 1'b0;
        n_checks++; if (out_data !== hdr_w(3'd3) || fill !== 6'd1) begin n_fail++; $display("FAIL basic_hdr: got %h fill=%0d exp %h fill=1", out_data, fill, hdr_w(3'd3)); end
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; mem_dat_stream = dat(i); tick();
            n_checks++; if (out_data !== pay_w(dat(i)) || out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_pay%0d: got %h exp %h", i, out_data, pay_w(dat(i))); end
        end
        valid = 1'b0; none = 1'b1; tick(); none = 1'b0;
        n_checks++; if (out_data !== trl_w(1'b0, 3'd3, 6'd4)) begin n_fail++; $display("FAIL basic_trl: got %h exp %h", out_data, trl_w(1'b0, 3'd3, 6'd4)); end
        tick();
        n_checks++; if (fill !== 6'd0 || out_valid !== 1'b0 || out_data !== 47'd0) begin n_fail++; $display("FAIL basic_empty: got fill=%0d valid=%b data=%h exp 0", fill, out_valid, out_data); end
    endtask

    task automatic test_overflow();
        logic [46:0] exp_w;
        out_ready = 1'b0;
        new_event = 1'b1; BX = 3'd2; tick(); new_event = 1'b0;
        for (int i = 0; i < 40; i++) begin
            valid = 1'b1; mem_dat_stream = dat(100 + i); tick();
        end
        valid = 1'b0; none = 1'b1; tick(); none = 1'b0;
        n_checks++; if (fill !== 6'd32) begin n_fail++; $display("FAIL ovf_fill: got %0d exp 32", fill); end
        tick();
        n_checks++; if (out_data !== hdr_w(3'd2) || out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_hold: got %h exp %h", out_data, hdr_w(3'd2)); end
        out_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            if (k == 0)       exp_w = hdr_w(3'd2);
            else if (k <= 30) exp_w = pay_w(dat(100 + k - 1));
            else              exp_w = trl_w(1'b1, 3'd2, 6'd30);
            n_checks++; if (out_data !== exp_w) begin n_fail++; $display("FAIL ovf_word%0d: got %h exp %h", k, out_data, exp_w); end
            tick();
        end
        n_checks++; if (fill !== 6'd0) begin n_fail++; $display("FAIL ovf_drained: got %0d exp 0", fill); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        new_event = 1'b1; BX = 3'd5; tick(); new_event = 1'b0;
        n_checks++; if (out_data !== hdr_w(3'd5)) begin n_fail++; $display("FAIL b2b_hdr5: got %h exp %h", out_data, hdr_w(3'd5)); end
        valid = 1'b1; mem_dat_stream = dat(200); tick(); valid = 1'b0;
        n_checks++; if (out_data !== pay_w(dat(200))) begin n_fail++; $display("FAIL b2b_pay5: got %h exp %h", out_data, pay_w(dat(200))); end
        new_event = 1'b1; BX = 3'd6; tick(); new_event = 1'b0;
        n_checks++; if (out_data !== trl_w(1'b0, 3'd5, 6'd1)) begin n_fail++; $display("FAIL b2b_trl5: got %h exp %h", out_data, trl_w(1'b0, 3'd5, 6'd1)); end
        valid = 1'b1; mem_dat_stream = dat(201); tick();
        n_checks++; if (out_data !== hdr_w(3'd6) || fill !== 6'd1) begin n_fail++; $display("FAIL b2b_hdr6: got %h fill=%0d exp %h fill=1", out_data, fill, hdr_w(3'd6)); end
        mem_dat_stream = dat(202); tick(); valid = 1'b0;
        n_checks++; if (out_data !== pay_w(dat(202))) begin n_fail++; $display("FAIL b2b_pay6: got %h exp %h", out_data, pay_w(dat(202))); end
        none = 1'b1; tick(); none = 1'b0;
        n_checks++; if (out_data !== trl_w(1'b1, 3'd6, 6'd1)) begin n_fail++; $display("FAIL b2b_trl6: got %h exp %h", out_data, trl_w(1'b1, 3'd6, 6'd1)); end
        tick();
        n_checks++; if (fill !== 6'd0) begin n_fail++; $display("FAIL b2b_empty: got %0d exp 0", fill); end
    endtask

    task automatic test_lost_event();
        out_ready = 1'b0;
        new_event = 1'b1; BX = 3'd1; tick(); new_event = 1'b0;
        for (int i = 0; i < 30; i++) begin
            valid = 1'b1; mem_dat_stream = dat(400 + i); tick();
        end
        valid = 1'b0; none = 1'b1; tick(); none = 1'b0;
        new_event = 1'b1; BX = 3'd7; tick(); new_event = 1'b0;
        n_checks++; if (lost_evt_cnt !== (STATS ? 8'd1 : 8'd0) || fill !== 6'd32) begin n_fail++; $display("FAIL lost_first: got lost=%0d fill=%0d exp lost=%0d fill=32", lost_evt_cnt, fill, STATS ? 1 : 0); end
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; mem_dat_stream = dat(500 + i); tick();
        end
        valid = 1'b0; none = 1'b1; tick(); none = 1'b0;
        n_checks++; if (fill !== 6'd32 || stray_cnt !== 8'd0) begin n_fail++; $display("FAIL lost_drop_words: got fill=%0d stray=%0d exp fill=32 stray=0", fill, stray_cnt); end
        new_event = 1'b1; BX = 3'd4; tick(); new_event = 1'b0;
        n_checks++; if (lost_evt_cnt !== (STATS ? 8'd2 : 8'd0)) begin n_fail++; $display("FAIL lost_second: got %0d exp %0d", lost_evt_cnt, STATS ? 2 : 0); end
        none = 1'b1; tick(); none = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (out_data !== hdr_w(3'd1)) begin n_fail++; $display("FAIL lost_head: got %h exp %h", out_data, hdr_w(3'd1)); end
        for (int k = 0; k < 31; k++) tick();
        n_checks++; if (out_data !== trl_w(1'b0, 3'd1, 6'd30) || fill !== 6'd1) begin n_fail++; $display("FAIL lost_tail: got %h fill=%0d exp %h fill=1", out_data, fill, trl_w(1'b0, 3'd1, 6'd30)); end
        tick();
        n_checks++; if (fill !== 6'd0) begin n_fail++; $display("FAIL lost_drained: got %0d exp 0", fill); end
    endtask

    task automatic test_stray_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; mem_dat_stream = dat(600 + i); tick();
            valid = 1'b0; tick();
        end
        n_checks++; if (stray_cnt !== (STATS ? 8'd3 : 8'd0) || fill !== 6'd0) begin n_fail++; $display("FAIL stray_count: got stray=%0d fill=%0d exp stray=%0d fill=0", stray_cnt, fill, STATS ? 3 : 0); end
        out_ready = 1'b0;
        new_event = 1'b1; BX = 3'd4; tick(); new_event = 1'b0;
        valid = 1'b1; mem_dat_stream = dat(300); tick();
        mem_dat_stream = dat(301); tick();
        n_checks++; if (fill !== 6'd3) begin n_fail++; $display("FAIL reset_pre_fill: got %0d exp 3", fill); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || fill !== 6'd0 || out_data !== 47'd0) begin n_fail++; $display("FAIL async_reset_fifo: got valid=%b fill=%0d data=%h exp 0", out_valid, fill, out_data); end
        n_checks++; if (stray_cnt !== 8'd0 || lost_evt_cnt !== 8'd0) begin n_fail++; $display("FAIL async_reset_cnt: got stray=%0d lost=%0d exp 0", stray_cnt, lost_evt_cnt); end
        valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        tick();
        new_event = 1'b1; BX = 3'd2; tick(); new_event = 1'b0;
        n_checks++; if (out_data !== hdr_w(3'd2) || fill !== 6'd1) begin n_fail++; $display("FAIL post_reset_hdr: got %h fill=%0d exp %h fill=1", out_data, fill, hdr_w(3'd2)); end
        none = 1'b1; tick(); none = 1'b0;
        n_checks++; if (out_data !== trl_w(1'b0, 3'd2, 6'd0)) begin n_fail++; $display("FAIL post_reset_trl: got %h exp %h", out_data, trl_w(1'b0, 3'd2, 6'd0)); end
        tick();
        n_checks++; if (fill !== 6'd0) begin n_fail++; $display("FAIL post_reset_empty: got %0d exp 0", fill); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_lost_event();
        test_stray_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
